// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: decode-control bundle layout, field widths and
// the ID/EX data bundle carried alongside the control word.
package pipe_pkg;

   localparam int CTRL_W     = 13;
   localparam int REG_ADDR_W = 5;
   localparam int FUNCT_W    = 6;
   localparam int WORD_W     = 32;

   localparam int CTRL_JAL_BIT      = 12;
   localparam int CTRL_JUMP_BIT     = 11;
   localparam int CTRL_BRANCH_BIT   = 10;
   localparam int CTRL_MEMWRITE_BIT = 9;
   localparam int CTRL_MEMREAD_BIT  = 8;
   localparam int CTRL_REGWRITE_BIT = 7;
   localparam int CTRL_MEMTOREG_BIT = 6;
   localparam int CTRL_ALUSRC_BIT   = 5;
   localparam int CTRL_REGDST_BIT   = 4;
   localparam int CTRL_ALUOP_HI     = 3;
   localparam int CTRL_ALUOP_LO     = 2;
   localparam int CTRL_SIGMUX_HI    = 1;
   localparam int CTRL_SIGMUX_LO    = 0;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   // Everything besides ctrl/valid; only meaningful while ex_valid is high.
   typedef struct packed {
      logic [WORD_W-1:0]     pc4;
      logic [WORD_W-1:0]     rd1;
      logic [WORD_W-1:0]     rd2;
      logic [WORD_W-1:0]     imm;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] shamt;
      logic [FUNCT_W-1:0]    funct;
   } idex_data_t;

   function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD_BIT];
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the
// instruction currently in ID.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic                  ex_valid_i,
   input  logic [CTRL_W-1:0]     ex_ctrl_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic [CTRL_W-1:0]     id_ctrl_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   output logic                  load_use_o
);

   logic ex_is_load;
   logic rt_nonzero;
   logic src_match;
   logic id_live;

   always_comb begin
      ex_is_load = ex_valid_i & ctrl_memread(ex_ctrl_i);
      // $zero is never a real dependency
      rt_nonzero = (ex_rt_i != '0);
      src_match  = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
      id_live    = (id_ctrl_i != CTRL_NOP);
      load_use_o = ex_is_load & rt_nonzero & src_match & id_live;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush > hold > load-use bubble > load priority.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = WORD_W
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic [DATA_W-1:0]     id_pc4,
   input  logic [DATA_W-1:0]     id_rd1,
   input  logic [DATA_W-1:0]     id_rd2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [REG_ADDR_W-1:0] id_shamt,
   input  logic [FUNCT_W-1:0]    id_funct,
   input  logic                  flush,
   input  logic                  ex_hold,
   output logic                  stall,
   output logic                  ex_valid,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [DATA_W-1:0]     ex_pc4,
   output logic [DATA_W-1:0]     ex_rd1,
   output logic [DATA_W-1:0]     ex_rd2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] ex_shamt,
   output logic [FUNCT_W-1:0]    ex_funct
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [15:0]           bubble_cnt
`endif
);

   logic                  valid_q, valid_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
   idex_data_t            data_q, data_d;
   idex_data_t            id_data;
   logic                  load_use;
   logic                  do_bubble;

   hazard_detect u_hazard (
      .ex_valid_i (valid_q),
      .ex_ctrl_i  (ctrl_q),
      .ex_rt_i    (data_q.rt),
      .id_ctrl_i  (id_ctrl),
      .id_rs_i    (id_rs),
      .id_rt_i    (id_rt),
      .load_use_o (load_use)
   );

   always_comb begin
      id_data.pc4   = id_pc4;
      id_data.rd1   = id_rd1;
      id_data.rd2   = id_rd2;
      id_data.imm   = id_imm;
      id_data.rs    = id_rs;
      id_data.rt    = id_rt;
      id_data.rd    = id_rd;
      id_data.shamt = id_shamt;
      id_data.funct = id_funct;
   end

   assign stall = (load_use & ~flush) | ex_hold;

   // Data fields only change on a real load; bubbles and flushes only kill ctrl/valid.
   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      data_d    = data_q;
      do_bubble = 1'b0;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_NOP;
      end else if (ex_hold) begin
         valid_d = valid_q;
      end else if (load_use) begin
         valid_d   = 1'b0;
         ctrl_d    = CTRL_NOP;
         do_bubble = 1'b1;
      end else begin
         valid_d = 1'b1;
         ctrl_d  = id_ctrl;
         data_d  = id_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [15:0] bcnt_q, bcnt_d;

   always_comb begin
      bcnt_d = bcnt_q;
      if (do_bubble && (bcnt_q != 16'hFFFF)) begin
         bcnt_d = bcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end

   assign bubble_cnt = bcnt_q;
`endif

   assign ex_valid = valid_q;
   assign ex_ctrl  = ctrl_q;
   assign ex_pc4   = data_q.pc4;
   assign ex_rd1   = data_q.rd1;
   assign ex_rd2   = data_q.rd2;
   assign ex_imm   = data_q.imm;
   assign ex_rs    = data_q.rs;
   assign ex_rt    = data_q.rt;
   assign ex_rd    = data_q.rd;
   assign ex_shamt = data_q.shamt;
   assign ex_funct = data_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; checks bubble_cnt when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;
   import pipe_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [CTRL_W-1:0]     id_ctrl;
   logic [31:0]           id_pc4, id_rd1, id_rd2, id_imm;
   logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd, id_shamt;
   logic [FUNCT_W-1:0]    id_funct;
   logic                  flush, ex_hold;
   logic                  stall, ex_valid;
   logic [CTRL_W-1:0]     ex_ctrl;
   logic [31:0]           ex_pc4, ex_rd1, ex_rd2, ex_imm;
   logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [FUNCT_W-1:0]    ex_funct;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [15:0]           bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;

   localparam logic [CTRL_W-1:0] C_LW  = 13'h1E0;
   localparam logic [CTRL_W-1:0] C_ADD = 13'h090;
   localparam logic [CTRL_W-1:0] C_ADDI = 13'h0A0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_ctrl(id_ctrl),
      .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_funct(id_funct), .flush(flush), .ex_hold(ex_hold),
      .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_funct(ex_funct)
`ifdef ID_EX_BUBBLE_CNT_EN
      , .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [CTRL_W-1:0] c, input logic [31:0] pc4,
                         input logic [4:0] rs, input logic [4:0] rt);
      id_ctrl  = c;
      id_pc4   = pc4;
      id_rd1   = pc4 + 32'h1000;
      id_rd2   = pc4 + 32'h2000;
      id_imm   = pc4 + 32'h3000;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rt + 5'd1;
      id_shamt = 5'd3;
      id_funct = 6'h20;
      #1;
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk(tag, {16'h0, bubble_cnt}, {16'h0, exp});
`endif
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
      set_id(CTRL_NOP, 32'h0, 5'd0, 5'd0);
      step();
      chk("rst_valid", {31'h0, ex_valid}, 32'h0);
      chk("rst_ctrl", {19'h0, ex_ctrl}, 32'h0);
      chk("rst_pc4", ex_pc4, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk_cnt("rst_cnt", 16'd0);
      ex_hold = 1'b1; #1;
      chk("rst_stall_hold", {31'h0, stall}, 32'h1);
      ex_hold = 1'b0;

      // Plain load
      @(negedge clk); rst = 1'b0;
      set_id(C_ADDI, 32'h40, 5'd1, 5'd3);
      step();
      chk("load_pc4", ex_pc4, 32'h40);
      chk("load_valid", {31'h0, ex_valid}, 32'h1);
      chk("load_ctrl", {19'h0, ex_ctrl}, {19'h0, C_ADDI});
      chk("load_rt", {27'h0, ex_rt}, 32'd3);
      chk("load_rd1", ex_rd1, 32'h1040);
      chk("load_imm", ex_imm, 32'h3040);

      // Asynchronous reset mid-stream
      #2; rst = 1'b1; #1;
      chk("mrst_valid", {31'h0, ex_valid}, 32'h0);
      chk("mrst_pc4", ex_pc4, 32'h0);
      chk("mrst_ctrl", {19'h0, ex_ctrl}, 32'h0);
      chk("mrst_rd2", ex_rd2, 32'h0);
      chk("mrst_stall", {31'h0, stall}, 32'h0);
      #1; rst = 1'b0;

      // Load-use bubble lasts exactly one cycle
      set_id(C_LW, 32'h44, 5'd2, 5'd8);
      step();
      chk("lw_ctrl", {19'h0, ex_ctrl}, {19'h0, C_LW});
      set_id(C_ADD, 32'h48, 5'd8, 5'd9);
      chk("lu_stall", {31'h0, stall}, 32'h1);
      step();
      chk("lu_bub_ctrl", {19'h0, ex_ctrl}, 32'h0);
      chk("lu_bub_valid", {31'h0, ex_valid}, 32'h0);
      chk("lu_bub_pc4", ex_pc4, 32'h44);
      chk("lu_stall_off", {31'h0, stall}, 32'h0);
      chk_cnt("lu_cnt1", 16'd1);
      step();
      chk("lu_ld_pc4", ex_pc4, 32'h48);
      chk("lu_ld_valid", {31'h0, ex_valid}, 32'h1);
      chk("lu_ld_ctrl", {19'h0, ex_ctrl}, {19'h0, C_ADD});

      // Load to $zero does not stall
      set_id(C_LW, 32'h4C, 5'd2, 5'd0);
      step();
      set_id(C_ADD, 32'h50, 5'd0, 5'd0);
      chk("zero_stall", {31'h0, stall}, 32'h0);
      step();
      chk("zero_pc4", ex_pc4, 32'h50);
      chk("zero_valid", {31'h0, ex_valid}, 32'h1);

      // NOP in ID never stalls
      set_id(C_LW, 32'h54, 5'd2, 5'd8);
      step();
      set_id(CTRL_NOP, 32'h58, 5'd8, 5'd8);
      chk("nop_stall", {31'h0, stall}, 32'h0);

      // Flush beats load-use
      set_id(C_ADD, 32'h58, 5'd8, 5'd4);
      flush = 1'b1; #1;
      chk("fl_stall", {31'h0, stall}, 32'h0);
      step();
      flush = 1'b0;
      chk("fl_valid", {31'h0, ex_valid}, 32'h0);
      chk("fl_ctrl", {19'h0, ex_ctrl}, 32'h0);
      chk("fl_pc4", ex_pc4, 32'h54);
      chk_cnt("fl_cnt", 16'd1);

      // Hold freezes every register for three cycles
      ex_hold = 1'b1;
      set_id(C_ADD, 32'h10, 5'd1, 5'd2);
      chk("hold_stall", {31'h0, stall}, 32'h1);
      step();
      chk("hold_pc4_a", ex_pc4, 32'h54);
      set_id(C_ADD, 32'h14, 5'd1, 5'd2);
      step();
      chk("hold_pc4_b", ex_pc4, 32'h54);
      set_id(C_ADD, 32'h18, 5'd1, 5'd2);
      step();
      chk("hold_pc4_c", ex_pc4, 32'h54);
      chk("hold_valid", {31'h0, ex_valid}, 32'h0);
      ex_hold = 1'b0; #1;
      step();
      chk("rel_pc4", ex_pc4, 32'h18);
      chk("rel_valid", {31'h0, ex_valid}, 32'h1);

      // Flush beats hold
      ex_hold = 1'b1; flush = 1'b1;
      set_id(C_ADD, 32'h1C, 5'd1, 5'd2);
      chk("flh_stall", {31'h0, stall}, 32'h1);
      step();
      ex_hold = 1'b0; flush = 1'b0;
      chk("flh_valid", {31'h0, ex_valid}, 32'h0);
      chk("flh_ctrl", {19'h0, ex_ctrl}, 32'h0);
      chk("flh_pc4", ex_pc4, 32'h18);

      // Two more load-use events, matching on rt then rs
      set_id(C_LW, 32'h20, 5'd2, 5'd5);
      step();
      set_id(C_ADD, 32'h24, 5'd0, 5'd5);
      chk("lu2_stall", {31'h0, stall}, 32'h1);
      step();
      chk("lu2_valid", {31'h0, ex_valid}, 32'h0);
      step();
      chk("lu2_pc4", ex_pc4, 32'h24);
      set_id(C_LW, 32'h28, 5'd2, 5'd7);
      step();
      set_id(C_ADD, 32'h2C, 5'd7, 5'd1);
      chk("lu3_stall", {31'h0, stall}, 32'h1);
      step();
      chk("lu3_ctrl", {19'h0, ex_ctrl}, 32'h0);
      chk_cnt("lu3_cnt", 16'd3);
      step();
      chk("lu3_pc4", ex_pc4, 32'h2C);
      chk("lu3_valid", {31'h0, ex_valid}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
